rotary_quad_decoder: RTL and testbench



---
 rtl/rotary_quad_if.sv | 13 +
 rtl/rotary_quad_decoder.sv | 81 ++++++++
 tb/tb_rotary_quad_decoder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rotary_quad_if.sv
// rotary_quad_if: encoder pins, clear and decoded outputs of the rotary encoder decoder
interface rotary_quad_if #(parameter int CNT_WIDTH = 5);
  logic rot_a;
  logic rot_b;
  logic clr;
  logic step_inc;
  logic step_dec;
  logic [CNT_WIDTH-1:0] count;
  logic [1:0] quad_state;
  logic err;
  modport master(output rot_a, rot_b, clr, input step_inc, step_dec, count, quad_state, err);
  modport slave(input rot_a, rot_b, clr, output step_inc, step_dec, count, quad_state, err);
endinterface

// File: rtl/rotary_quad_decoder.sv
// rotary_quad_decoder: synchronised, filtered Gray decoder emitting one pulse per detent
module rotary_quad_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYCLES = 8,
  parameter int STEPS_PER_DETENT = 4,
  parameter int CNT_WIDTH = 5
) (
  input logic clk,
  input logic rst,
  rotary_quad_if.slave bus
);
  localparam int FC_W = $clog2(FILTER_CYCLES) + 1;
  localparam int ACC_W = $clog2(STEPS_PER_DETENT) + 2;
  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic [1:0] s, cand_q, qs_q, d;
  logic [FC_W-1:0] fc_q;
  logic seeded_q, err_q, inc_q, dec_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic accept, fwd, bwd, bad, inc_d, dec_d;
  assign s = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  assign accept = s == cand_q && (cand_q != qs_q || !seeded_q) && fc_q == FC_W'(FILTER_CYCLES - 1);
  // Gray-to-binary gives the ring position: +1 is CW, -1 is CCW, 2 means a skipped state
  assign d = {cand_q[1], ^cand_q} - {qs_q[1], ^qs_q};
  assign fwd = accept && seeded_q && d == 2'd1;
  assign bwd = accept && seeded_q && d == 2'd3;
  assign bad = accept && seeded_q && d == 2'd2;
  always_comb begin
    acc_d = acc_q + (fwd ? ACC_W'(1) : bwd ? {ACC_W{1'b1}} : '0);
    inc_d = acc_d == ACC_W'(STEPS_PER_DETENT);
    dec_d = acc_d == ACC_W'(-STEPS_PER_DETENT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      cand_q <= '0;
      fc_q <= '0;
      qs_q <= '0;
      seeded_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], bus.rot_a};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], bus.rot_b};
      if (s != cand_q) begin
        cand_q <= s;
        fc_q <= '0;
      end else if (accept) begin
        fc_q <= '0;
      end else if (fc_q != FC_W'(FILTER_CYCLES - 1)) begin
        fc_q <= fc_q + 1'b1;
      end
      if (accept) begin
        qs_q <= cand_q;
        seeded_q <= 1'b1;
      end
      if (bus.clr) begin
        acc_q <= '0;
        cnt_q <= '0;
        err_q <= 1'b0;
        inc_q <= 1'b0;
        dec_q <= 1'b0;
      end else begin
        acc_q <= (inc_d || dec_d) ? '0 : acc_d;
        cnt_q <= inc_d ? cnt_q + 1'b1 : dec_d ? cnt_q - 1'b1 : cnt_q;
        err_q <= err_q | bad;
        inc_q <= inc_d;
        dec_q <= dec_d;
      end
    end
  end
  assign bus.step_inc = inc_q;
  assign bus.step_dec = dec_q;
  assign bus.count = cnt_q;
  assign bus.quad_state = qs_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_rotary_quad_decoder.sv
// tb_rotary_quad_decoder: directed and random encoder motion checked against a position model
module tb_rotary_quad_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  rotary_quad_if #(.CNT_WIDTH(5)) bus();
  rotary_quad_decoder #(.SYNC_STAGES(2), .FILTER_CYCLES(8), .STEPS_PER_DETENT(4), .CNT_WIDTH(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int inc_seen = 0;
  int dec_seen = 0;
  bit both_seen = 1'b0;
  logic [1:0] cw_seq[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] m_qs = 2'b00;
  logic [1:0] pins = 2'b00;
  int m_cnt = 0, m_acc = 0, m_err = 0, m_seeded = 0, m_inc = 0, m_dec = 0;
  always @(posedge clk) begin
    #1;
    if (bus.step_inc) inc_seen++;
    if (bus.step_dec) dec_seen++;
    if (bus.step_inc && bus.step_dec) both_seen = 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int pos(input logic [1:0] v);
    for (int i = 0; i < 4; i++) if (cw_seq[i] == v) return i;
    return 0;
  endfunction
  task automatic model_reset();
    m_qs = 2'b00; m_cnt = 0; m_acc = 0; m_err = 0; m_seeded = 0;
  endtask
  task automatic model_clr();
    m_cnt = 0; m_acc = 0; m_err = 0;
  endtask
  task automatic model_apply(input logic [1:0] v);
    int d;
    if (m_seeded == 0) begin
      m_seeded = 1;
      m_qs = v;
      return;
    end
    if (v == m_qs) return;
    d = (pos(v) - pos(m_qs) + 4) % 4;
    if (d == 2) m_err = 1;
    else m_acc += (d == 1) ? 1 : -1;
    if (m_acc == 4) begin
      m_inc++; m_cnt = (m_cnt + 1) % 32; m_acc = 0;
    end else if (m_acc == -4) begin
      m_dec++; m_cnt = (m_cnt + 31) % 32; m_acc = 0;
    end
    m_qs = v;
  endtask
  task automatic drive(input logic [1:0] v);
    bus.rot_a = v[1];
    bus.rot_b = v[0];
    pins = v;
  endtask
  task automatic move(input logic [1:0] v, input int hold);
    drive(v);
    repeat (hold) @(negedge clk);
    model_apply(v);
  endtask
  task automatic glitch(input logic [1:0] v, input int len);
    logic [1:0] back;
    back = pins;
    drive(v);
    repeat (len) @(negedge clk);
    drive(back);
    repeat (15) @(negedge clk);
  endtask
  task automatic do_clr();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    model_clr();
    @(negedge clk);
  endtask
  task automatic verify(input string tag);
    chk({tag, "/quad_state"}, 32'(bus.quad_state), 32'(m_qs));
    chk({tag, "/count"}, 32'(bus.count), 32'(m_cnt));
    chk({tag, "/err"}, 32'(bus.err), 32'(m_err));
    chk({tag, "/inc_pulses"}, inc_seen, m_inc);
    chk({tag, "/dec_pulses"}, dec_seen, m_dec);
  endtask
  initial begin
    logic [1:0] nxt;
    int r;
    bus.clr = 1'b0;
    drive(2'b11);
    repeat (3) @(negedge clk);
    chk("reset/quad_state", 32'(bus.quad_state), 0);
    chk("reset/count", 32'(bus.count), 0);
    chk("reset/err", 32'(bus.err), 0);
    chk("reset/step_inc", 32'(bus.step_inc), 0);
    chk("reset/step_dec", 32'(bus.step_dec), 0);
    rst = 1'b0;
    model_reset();
    repeat (12) @(negedge clk);
    model_apply(2'b11);
    verify("seed11");
    move(2'b10, 20);
    move(2'b00, 20);
    do_clr();
    verify("to00");
    move(2'b01, 20);
    move(2'b11, 20);
    move(2'b10, 20);
    drive(2'b00);
    repeat (10) @(negedge clk);
    chk("latency/early", 32'(bus.step_inc), 0);
    @(negedge clk);
    chk("latency/pulse", 32'(bus.step_inc), 1);
    @(negedge clk);
    chk("latency/single", 32'(bus.step_inc), 0);
    repeat (8) @(negedge clk);
    model_apply(2'b00);
    verify("cw_detent");
    do_clr();
    move(2'b10, 20);
    move(2'b11, 20);
    move(2'b01, 20);
    move(2'b00, 20);
    verify("ccw_wrap");
    for (int i = 0; i < 32; i++) begin
      move(2'b01, 12);
      move(2'b11, 12);
      move(2'b10, 12);
      move(2'b00, 12);
    end
    verify("cw32_wrap");
    glitch(2'b01, 5);
    verify("glitch");
    move(2'b11, 20);
    verify("illegal");
    do_clr();
    verify("clr_err");
    move(2'b10, 20);
    move(2'b00, 20);
    do_clr();
    move(2'b01, 20);
    move(2'b11, 20);
    move(2'b10, 20);
    drive(2'b00);
    repeat (10) @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    m_qs = 2'b00;
    model_clr();
    repeat (10) @(negedge clk);
    verify("clr_vs_step");
    move(2'b01, 20);
    move(2'b11, 20);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (15) @(negedge clk);
    model_apply(2'b11);
    verify("reseed");
    move(2'b10, 20);
    move(2'b00, 20);
    move(2'b01, 20);
    verify("after_rst_partial");
    move(2'b11, 20);
    verify("after_rst_detent");
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) move(cw_seq[(pos(m_qs) + 1) % 4], $urandom_range(12, 25));
      else if (r < 75) move(cw_seq[(pos(m_qs) + 3) % 4], $urandom_range(12, 25));
      else if (r < 85) move(cw_seq[(pos(m_qs) + 2) % 4], $urandom_range(12, 25));
      else if (r < 95) begin
        nxt = m_qs ^ 2'($urandom_range(1, 3));
        glitch(nxt, $urandom_range(1, 6));
      end else do_clr();
      verify("random");
    end
    chk("never_both_pulses", 32'(both_seen), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
